vx_mem_perf_reader: RTL and testbench
=====================================

// Module: vx_mem_perf_reader
// PURPOSE
//  Read-side consumer of the memory-subsystem performance counter bundle
//  (icache/dcache/l2/l3/smem/mem counters, flattened by the caller).
//  Serves 32-bit CSR-style reads of CTR_W-bit counters over a valid/ready
//  request/response pair. A LO read snapshots the whole counter, so the
//  following HI read of the same index is tear-free. Sits between the
//  perf bundle and the core CSR unit.
// PARAMETERS
//  NUM_CTRS  16  number of counters in perf_ctrs
//  CTR_W     44  counter width (PERF_CTR_BITS); legal range 33..64
//  IDX_W     $clog2(NUM_CTRS)  request index width (derived, do not override)
// PORTS
//  clk        in   1                  clock
//  reset_n    in   1                  async active-low reset
//  perf_ctrs  in   NUM_CTRS*CTR_W     live counters; ctr i = [i*CTR_W +: CTR_W]
//  snap_clr   in   1                  invalidate held snapshot
//  req_valid  in   1                  read request valid
//  req_ready  out  1                  read request ready
//  req_idx    in   IDX_W              counter index
//  req_hi     in   1                  0: bits[31:0], 1: bits[63:32] (zero-ext)
//  rsp_valid  out  1                  response valid
//  rsp_ready  in   1                  response ready
//  rsp_data   out  32                 read data
//  rsp_err    out  1                  index >= NUM_CTRS (rsp_data = 0)
// BEHAVIOUR
//  Reset: async on reset_n low; state=IDLE, req_ready=1, rsp_valid=0,
//   rsp_data=0, rsp_err=0, snapshot=0, snap_vld=0, snap_idx=0.
//  FSM: IDLE -> RSP on accept (req_valid & req_ready);
//   RSP -> IDLE on rsp_valid & rsp_ready. No other transitions.
//  req_ready = (state==IDLE). One outstanding request at a time.
//  Latency: rsp_valid rises the cycle after accept. rsp_data and rsp_err
//   are registered and hold stable while rsp_valid & !rsp_ready.
//  Width: counter zero-extended to 64 bits before slicing; bits >= CTR_W
//   read as 0.
//  LO accept (req_hi=0, idx valid): snapshot <= zext(ctr[idx]) sampled in the
//   accept cycle; snap_idx <= idx; snap_vld <= 1; rsp_data <= snapshot[31:0]
//   (the just-sampled value).
//  HI accept, snap_vld & snap_idx==idx: rsp_data <= snapshot[63:32]
//   (held value, not live); snapshot unchanged, stays valid.
//  HI accept, no matching snapshot: resample ctr[idx] into snapshot and
//   snap_idx <= idx, set snap_vld, return new [63:32].
//  Invalid idx (>= NUM_CTRS): rsp_err=1, rsp_data=0, snapshot untouched.
//  snap_clr: snap_vld <= 0 next cycle. If it coincides with a snapshot-
//   loading accept, the new snapshot wins (snap_vld=1).
//  perf_ctrs is sampled only in accept cycles. Changes while in RSP do not
//   alter rsp_data.
//  reset_n low mid-transaction: response dropped, outputs to reset values.
// TESTING
//  T1 reset: assert reset_n=0 mid-RSP -> rsp_valid=0, req_ready=1
//     immediately (async).
//  T2 tear-free: ctr3=0x0_FFFF_FFFF, read LO idx3 -> 0xFFFF_FFFF; ctr3
//     then 0x1_0000_0000; HI idx3 -> 0x0.
//  T3 HI mismatch: LO idx3 then HI idx5 with ctr5=0x2_0000_0007 -> 0x2;
//     next HI idx5 -> 0x2 from held snapshot.
//  T4 backpressure: rsp_ready=0 for 5 cycles with ctr toggling -> rsp_data
//     stable, req_ready=0 throughout; completes on rsp_ready=1.
//  T5 NUM_CTRS=12, req_idx=13 -> rsp_err=1, rsp_data=0; prior snapshot
//     still serves HI.
//  T6 snap_clr same cycle as LO accept idx2 -> snap_vld=1; snap_clr alone,
//     then HI idx2 -> live resample.

Source files
------------

// File: rtl/vx_mem_perf_reader_if.sv
// Request/response bundle between the CSR unit (master) and the perf counter reader (slave).
// One outstanding 32-bit read at a time over valid/ready.
interface vx_mem_perf_reader_if #(
    parameter int IDX_W = 4
);
    logic             req_valid;
    logic             req_ready;
    logic [IDX_W-1:0] req_idx;
    logic             req_hi;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [31:0]      rsp_data;
    logic             rsp_err;

    modport master (
        output req_valid, req_idx, req_hi, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_err
    );

    modport slave (
        input  req_valid, req_idx, req_hi, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_err
    );
endinterface

// File: rtl/vx_mem_perf_reader.sv
// Serves 32-bit halves of wide perf counters; a LO read snapshots the whole
// counter so the following HI read of the same index is tear-free.
//
//  state  | meaning
//  IDLE   | ready for a request (req_ready=1)
//  RSP    | response registered, waiting for rsp_ready
module vx_mem_perf_reader #(
    parameter  int NUM_CTRS = 16,
    parameter  int CTR_W    = 44,
    localparam int IDX_W    = (NUM_CTRS > 1) ? $clog2(NUM_CTRS) : 1
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NUM_CTRS*CTR_W-1:0] perf_ctrs,
    input  logic                      snap_clr,
    vx_mem_perf_reader_if.slave       bus
);
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RSP  = 1'b1;

    logic [0:0]       state;
    logic [63:0]      snapshot;
    logic             snap_vld;
    logic [IDX_W-1:0] snap_idx;
    logic [31:0]      rsp_data_q;
    logic             rsp_err_q;

    logic [CTR_W-1:0] sel_ctr;
    logic [63:0]      ctr_ext;
    logic             idx_ok;
    logic             accept;
    logic             snap_hit;

    always_comb begin
        sel_ctr = '0;
        for (int i = 0; i < NUM_CTRS; i++) begin
            if (int'(bus.req_idx) == i) sel_ctr = perf_ctrs[i*CTR_W +: CTR_W];
        end
    end

    assign ctr_ext  = 64'(sel_ctr);
    assign idx_ok   = int'(bus.req_idx) < NUM_CTRS;
    assign accept   = bus.req_valid && (state == S_IDLE);
    assign snap_hit = bus.req_hi && snap_vld && (snap_idx == bus.req_idx);

    assign bus.req_ready = (state == S_IDLE);
    assign bus.rsp_valid = (state == S_RSP);
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_err   = rsp_err_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            snapshot   <= '0;
            snap_vld   <= 1'b0;
            snap_idx   <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            // a snapshot-loading accept below overrides this clear
            if (snap_clr) snap_vld <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        state <= S_RSP;
                        if (!idx_ok) begin
                            rsp_err_q  <= 1'b1;
                            rsp_data_q <= '0;
                        end else begin
                            rsp_err_q <= 1'b0;
                            if (snap_hit) begin
                                rsp_data_q <= snapshot[63:32];
                            end else begin
                                snapshot   <= ctr_ext;
                                snap_idx   <= bus.req_idx;
                                snap_vld   <= 1'b1;
                                rsp_data_q <= bus.req_hi ? ctr_ext[63:32] : ctr_ext[31:0];
                            end
                        end
                    end
                end
                default: begin
                    if (bus.rsp_ready) state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_vx_mem_perf_reader.sv
// Randomized + directed bench for vx_mem_perf_reader, checked every cycle
// against a transaction-level model of the snapshot rules.
module tb_vx_mem_perf_reader;
    localparam int NC = 12;
    localparam int CW = 44;
    localparam int IW = 4;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic snap_clr = 1'b0;
    logic [CW-1:0] ctr [NC];
    logic [NC*CW-1:0] perf_ctrs;

    int checks = 0;
    int failures = 0;

    vx_mem_perf_reader_if #(.IDX_W(IW)) bus ();

    vx_mem_perf_reader #(.NUM_CTRS(NC), .CTR_W(CW)) dut (
        .clk(clk), .reset_n(reset_n), .perf_ctrs(perf_ctrs), .snap_clr(snap_clr), .bus(bus)
    );

    always #5 clk = ~clk;

    always_comb begin
        perf_ctrs = '0;
        for (int i = 0; i < NC; i++) perf_ctrs[i*CW +: CW] = ctr[i];
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // model: held snapshot plus queue of expected responses
    logic [63:0] m_snap;
    logic        m_vld;
    logic [IW-1:0] m_idx;
    logic [32:0] exp_q [$];   // {err, data}
    bit          busy;

    task automatic model_reset();
        m_snap = '0; m_vld = 1'b0; m_idx = '0; busy = 1'b0;
        exp_q.delete();
    endtask

    always @(negedge clk) begin
        if (reset_n) begin
            check("req_ready", 64'(bus.req_ready), 64'(!busy));
            check("rsp_valid", 64'(bus.rsp_valid), 64'(busy));
            if (busy && exp_q.size() > 0) begin
                check("rsp_data", 64'(bus.rsp_data), 64'(exp_q[0][31:0]));
                check("rsp_err", 64'(bus.rsp_err), 64'(exp_q[0][32]));
            end
            if (bus.rsp_valid && bus.rsp_ready && busy) begin
                void'(exp_q.pop_front());
                busy = 1'b0;
            end else if (bus.req_valid && bus.req_ready && !busy) begin
                logic old_vld;
                logic [63:0] live;
                int idx;
                idx = int'(bus.req_idx);
                old_vld = m_vld;
                if (snap_clr) m_vld = 1'b0;
                if (idx >= NC) begin
                    exp_q.push_back({1'b1, 32'h0});
                end else if (bus.req_hi && old_vld && m_idx == bus.req_idx) begin
                    exp_q.push_back({1'b0, m_snap[63:32]});
                end else begin
                    live = 64'(ctr[idx]);
                    m_snap = live; m_idx = bus.req_idx; m_vld = 1'b1;
                    exp_q.push_back({1'b0, bus.req_hi ? live[63:32] : live[31:0]});
                end
                busy = 1'b1;
            end else if (snap_clr) begin
                m_vld = 1'b0;
            end
        end
    end

    function automatic logic [CW-1:0] rnd_ctr();
        logic [63:0] r;
        r = {$urandom, $urandom};
        case ($urandom_range(0, 3))
            0: return CW'(r[31:0]);
            1: return CW'(64'h0_FFFF_FFFF - 64'(r[3:0]));
            2: return CW'(64'h1_0000_0000 + 64'(r[3:0]));
            default: return r[CW-1:0];
        endcase
    endfunction

    task automatic do_read(input int idx, input bit hi, input int stall, input bit toggle,
                           input bit clr, output logic [31:0] data, output logic err);
        bit got;
        got = 1'b0; data = '0; err = 1'b0;
        @(posedge clk) #1;
        bus.req_valid = 1'b1; bus.req_idx = IW'(idx); bus.req_hi = hi; bus.rsp_ready = 1'b0;
        snap_clr = clr;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (bus.req_ready) break;
        end
        @(posedge clk) #1;
        bus.req_valid = 1'b0; snap_clr = 1'b0;
        for (int s = 0; s < stall; s++) begin
            if (toggle) ctr[(idx < NC) ? idx : 0] = rnd_ctr();
            @(posedge clk) #1;
        end
        bus.rsp_ready = 1'b1;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (bus.rsp_valid) begin
                data = bus.rsp_data; err = bus.rsp_err; got = 1'b1;
                break;
            end
        end
        @(posedge clk) #1;
        bus.rsp_ready = 1'b0;
        check("rsp_timeout", 64'(got), 64'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        logic e;
        bus.req_valid = 1'b0; bus.req_idx = '0; bus.req_hi = 1'b0; bus.rsp_ready = 1'b0;
        for (int i = 0; i < NC; i++) ctr[i] = '0;
        model_reset();
        #3;
        check("rst_req_ready", 64'(bus.req_ready), 64'd1);
        check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check("rst_rsp_data", 64'(bus.rsp_data), 64'd0);
        check("rst_rsp_err", 64'(bus.rsp_err), 64'd0);
        @(posedge clk) #2 reset_n = 1'b1;

        // T1: async reset while a response is pending
        ctr[1] = 44'h123_4567_89AB;
        @(posedge clk) #1;
        bus.req_valid = 1'b1; bus.req_idx = 4'd1; bus.req_hi = 1'b0;
        @(posedge clk) #1;
        bus.req_valid = 1'b0;
        @(posedge clk) #3;
        check("t1_pending", 64'(bus.rsp_valid), 64'd1);
        reset_n = 1'b0;
        model_reset();
        #1;
        check("t1_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check("t1_req_ready", 64'(bus.req_ready), 64'd1);
        check("t1_rsp_data", 64'(bus.rsp_data), 64'd0);
        @(posedge clk) #2 reset_n = 1'b1;

        // T2: tear-free LO/HI
        ctr[3] = 44'h0_FFFF_FFFF;
        do_read(3, 1'b0, 0, 1'b0, 1'b0, d, e);
        check("t2_lo", 64'(d), 64'hFFFF_FFFF);
        ctr[3] = 44'h1_0000_0000;
        do_read(3, 1'b1, 0, 1'b0, 1'b0, d, e);
        check("t2_hi", 64'(d), 64'h0);

        // T3: HI on another index resamples, then is held
        ctr[5] = 44'h2_0000_0007;
        do_read(3, 1'b0, 0, 1'b0, 1'b0, d, e);
        do_read(5, 1'b1, 0, 1'b0, 1'b0, d, e);
        check("t3_hi_miss", 64'(d), 64'h2);
        ctr[5] = 44'h5_0000_0000;
        do_read(5, 1'b1, 0, 1'b0, 1'b0, d, e);
        check("t3_hi_held", 64'(d), 64'h2);

        // T4: backpressure with the counter changing underneath
        ctr[7] = 44'hABC_1234_5678;
        do_read(7, 1'b0, 5, 1'b1, 1'b0, d, e);
        check("t4_stable", 64'(d), 64'h1234_5678);

        // T5: invalid index leaves the snapshot alone
        ctr[5] = 44'h9_8765_4321;
        do_read(5, 1'b0, 0, 1'b0, 1'b0, d, e);
        check("t5_lo", 64'(d), 64'h8765_4321);
        do_read(13, 1'b0, 1, 1'b0, 1'b0, d, e);
        check("t5_err", 64'(e), 64'd1);
        check("t5_err_data", 64'(d), 64'd0);
        ctr[5] = 44'h0_0000_0000;
        do_read(5, 1'b1, 0, 1'b0, 1'b0, d, e);
        check("t5_hi_held", 64'(d), 64'h9);
        check("t5_hi_err", 64'(e), 64'd0);

        // T6: clear coinciding with LO load loses; clear alone forces resample
        ctr[2] = 44'h3_0000_0011;
        do_read(2, 1'b0, 0, 1'b0, 1'b1, d, e);
        check("t6_lo", 64'(d), 64'h11);
        ctr[2] = 44'h4_0000_0000;
        do_read(2, 1'b1, 0, 1'b0, 1'b0, d, e);
        check("t6_hi_held", 64'(d), 64'h3);
        @(posedge clk) #1 snap_clr = 1'b1;
        @(posedge clk) #1 snap_clr = 1'b0;
        ctr[2] = 44'h6_0000_0000;
        do_read(2, 1'b1, 0, 1'b0, 1'b0, d, e);
        check("t6_hi_live", 64'(d), 64'h6);

        // random traffic, checked cycle by cycle by the model
        for (int t = 0; t < 400; t++) begin
            if ($urandom_range(0, 3) == 0) ctr[$urandom_range(0, NC-1)] = rnd_ctr();
            if ($urandom_range(0, 7) == 0) begin
                @(posedge clk) #1 snap_clr = 1'b1;
                @(posedge clk) #1 snap_clr = 1'b0;
            end
            do_read(int'($urandom_range(0, 15)), 1'(($urandom_range(0, 1))),
                    int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 5) == 0), d, e);
        end

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
